// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per clock, result {remainder, quotient}.
// Optional abort input annul_i is present when DIV_ANNUL_EN is defined.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
`ifdef DIV_ANNUL_EN
  input  logic               annul_i,
`endif
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     dvd_q;
  logic [WIDTH-1:0]     dvs_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 neg_quot_q;
  logic                 neg_rem_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic                 annul;
  logic [WIDTH-1:0]     mag1_d;
  logic [WIDTH-1:0]     mag2_d;
  logic [WIDTH:0]       partial_d;
  logic                 take_d;
  logic [WIDTH:0]       diff_d;
  logic [WIDTH-1:0]     quot_fix_d;
  logic [WIDTH-1:0]     rem_fix_d;

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = 1'b0;
`endif

  // The partial remainder is kept one bit wider so divisors with the MSB set
  // in unsigned mode still compare correctly after the shift.
  always_comb begin
    mag1_d     = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    mag2_d     = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    partial_d  = {rem_q, dvd_q[WIDTH-1]};
    take_d     = (partial_d >= {1'b0, dvs_q});
    diff_d     = partial_d - {1'b0, dvs_q};
    quot_fix_d = neg_quot_q ? ('0 - dvd_q) : dvd_q;
    rem_fix_d  = neg_rem_q  ? ('0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (start_i && !annul) begin
            dvd_q      <= mag1_d;
            dvs_q      <= mag2_d;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i && opdata1_i[WIDTH-1];
            state_q    <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (annul) begin
            state_q <= FREE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        ON: begin
          if (annul) begin
            state_q <= FREE;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_LAST) begin
            // Dividend register shifts out dividend bits and shifts in quotient bits.
            rem_q <= take_d ? diff_d[WIDTH-1:0] : partial_d[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], take_d};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= {rem_fix_d, quot_fix_d};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (!start_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= FREE;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
